// File: rtl/linx_platform_pkg.sv
// Shared platform types and constants for the Zybo PL wrapper blocks.
//   uart_state_e                   serializer FSM states
//   UART_CLKS_PER_BIT_125M_115200  bit period at 125 MHz for 115200 baud
//   UART_DATA_BITS                 payload bits per UART frame
package linx_platform_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    localparam int UART_CLKS_PER_BIT_125M_115200 = 1085;
    localparam int UART_DATA_BITS                = 8;

endpackage

// File: rtl/linx_byte_fifo.sv
// Small byte FIFO for the console serializer.
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        synchronous clear (highest priority)
//   push, data   write request and payload
//   pop          read request; ignored when empty
//   head         byte at the read pointer (valid when not empty)
//   full, empty  occupancy flags
//   level        registered occupancy, 0..DEPTH
// A push while full is still accepted when a pop happens on the same edge.
module linx_byte_fifo
    import linx_platform_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      push,
    input  logic [UART_DATA_BITS-1:0] data,
    input  logic                      pop,
    output logic [UART_DATA_BITS-1:0] head,
    output logic                      full,
    output logic                      empty,
    output logic [LW-1:0]             level
);

    logic [UART_DATA_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]             rd_ptr;
    logic [AW-1:0]             wr_ptr;
    logic                      pop_ok;
    logic                      push_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      level <= level + 1'b1;
            else if (pop_ok && !push_ok) level <= level - 1'b1;
        end
    end

    // Storage needs no reset; pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem[wr_ptr] <= data;
    end

endmodule

// File: rtl/linx_uart_tx_serializer.sv
// Buffers core console bytes and serialises them 8N1 onto a PL pin.
//   aclk, aresetn  clock, asynchronous active-low reset
//   flush          synchronous clear of FIFO, frame and status
//   in_valid/data  single-cycle byte strobes, no backpressure
//   uart_tx        serial line, idles high
//   busy           frame on the line or FIFO non-empty
//   level          FIFO occupancy
//   overflow       sticky byte-dropped flag
//   drop_count     saturating dropped-byte count
//   clear_status   synchronous clear of overflow and drop_count
module linx_uart_tx_serializer
    import linx_platform_pkg::*;
#(
    parameter  int DEPTH        = 16,
    parameter  int CLKS_PER_BIT = UART_CLKS_PER_BIT_125M_115200,
    parameter  int CNT_W        = 16,
    localparam int LW           = $clog2(DEPTH) + 1
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [UART_DATA_BITS-1:0] in_data,
    output logic                      uart_tx,
    output logic                      busy,
    output logic [LW-1:0]             level,
    output logic                      overflow,
    output logic [CNT_W-1:0]          drop_count,
    input  logic                      clear_status
);

    localparam int            BW        = $clog2(CLKS_PER_BIT);
    localparam int            IW        = $clog2(UART_DATA_BITS);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(UART_DATA_BITS - 1);

    uart_state_e               state;
    logic [BW-1:0]             baud_cnt;
    logic [IW-1:0]             bit_idx;
    logic [UART_DATA_BITS-1:0] shift;
    logic [UART_DATA_BITS-1:0] head;
    logic                      full;
    logic                      empty;
    logic                      baud_done;
    logic                      pop;
    logic                      drop;

    assign baud_done = (baud_cnt == BAUD_LAST);
    // Pop exactly on the edges where the FSM loads a new frame.
    assign pop  = ~flush & ~empty &
                  ((state == IDLE) | ((state == STOP) & baud_done));
    assign drop = in_valid & ~flush & full & ~pop;
    assign busy = (state != IDLE) | (level != '0);

    linx_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (aclk),
        .rst_n (aresetn),
        .clear (flush),
        .push  (in_valid & ~flush),
        .data  (in_data),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            uart_tx  <= 1'b1;
        end else if (flush) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            uart_tx  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        shift    <= head;
                        uart_tx  <= 1'b0;
                        baud_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        uart_tx  <= shift[0];
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == BIT_LAST) begin
                            uart_tx <= 1'b1;
                            state   <= STOP;
                        end else begin
                            shift   <= shift >> 1;
                            uart_tx <= shift[1];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        // Chain straight into the next start bit, no idle gap.
                        if (!empty) begin
                            shift   <= head;
                            uart_tx <= 1'b0;
                            state   <= START;
                        end else begin
                            state   <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (flush || clear_status) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_linx_uart_tx_serializer.sv
module tb_linx_uart_tx_serializer;

    localparam int DEPTH = 4;
    localparam int CPB   = 4;
    localparam int CW    = 3;
    localparam int FRAME = 10 * CPB;
    localparam int MAXD  = (1 << CW) - 1;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          clear_status = 1'b0;
    logic          uart_tx;
    logic          busy;
    logic [2:0]    level;
    logic          overflow;
    logic [CW-1:0] drop_count;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    linx_uart_tx_serializer #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .CNT_W(CW)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .uart_tx      (uart_tx),
        .busy         (busy),
        .level        (level),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .clear_status (clear_status)
    );

    logic [8:0] obs;
    assign obs = {uart_tx, busy, level, overflow, drop_count};

    // Behavioural model: a byte queue plus "cycles left in the current frame".
    logic [7:0] m_q[$];
    int         m_rem = 0;
    logic [9:0] m_frame = 10'h3FF;
    logic       m_ovf = 1'b0;
    int         m_drops = 0;

    function automatic logic [8:0] exp_vec();
        logic t;
        if (m_rem == 0) t = 1'b1;
        else            t = m_frame[(FRAME - m_rem) / CPB];
        return {t, (m_rem > 0 || m_q.size() > 0), 3'(m_q.size()), m_ovf, CW'(m_drops)};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_rem   = 0;
        m_ovf   = 1'b0;
        m_drops = 0;
    endtask

    task automatic model_edge(input logic v, input logic [7:0] d, input logic fl, input logic cs);
        bit         was_full;
        bit         popped;
        logic [7:0] b;
        if (fl) begin
            model_reset();
            return;
        end
        was_full = (m_q.size() == DEPTH);
        popped   = (m_q.size() > 0) && (m_rem <= 1);
        if (m_rem > 0) m_rem--;
        if (popped) begin
            b       = m_q.pop_front();
            m_frame = {1'b1, b, 1'b0};
            m_rem   = FRAME;
        end
        if (v) begin
            if (!was_full || popped) m_q.push_back(d);
            else begin
                m_ovf = 1'b1;
                if (m_drops < MAXD) m_drops++;
            end
        end
        if (cs) begin
            m_ovf   = 1'b0;
            m_drops = 0;
        end
    endtask

    // Independent line receiver: samples bit centres on the falling clock edge.
    logic [7:0] rx_q[$];
    logic [7:0] rx_sh;
    bit         rx_on = 0;
    bit         rx_kill = 0;
    int         rx_cnt = 0;
    int         rx_k = 0;
    int         rx_ferr = 0;

    always @(negedge aclk) begin
        if (!aresetn || rx_kill) begin
            rx_on = 0;
        end else begin
            if (rx_on) rx_cnt++;
            else if (uart_tx === 1'b0) begin
                rx_on  = 1;
                rx_cnt = 0;
            end
            if (rx_on && (rx_cnt % CPB) == CPB / 2) begin
                rx_k = rx_cnt / CPB;
                if (rx_k == 0) begin
                    if (uart_tx !== 1'b0) rx_on = 0;
                end else if (rx_k <= 8) begin
                    rx_sh[rx_k-1] = uart_tx;
                end else begin
                    if (uart_tx === 1'b1) rx_q.push_back(rx_sh);
                    else rx_ferr++;
                    rx_on = 0;
                end
            end
        end
    end

    task automatic step(input logic v, input logic [7:0] d, input logic fl, input logic cs);
        in_valid     = v;
        in_data      = d;
        flush        = fl;
        clear_status = cs;
        rx_kill      = fl;
        @(posedge aclk);
        if (aresetn) model_edge(v, d, fl, cs);
        #1;
        in_valid     = 1'b0;
        flush        = 1'b0;
        clear_status = 1'b0;
        rx_kill      = 0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        model_reset();
        step(1'b1, 8'hA7, 1'b0, 1'b0);
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        checks++;
        if (obs !== 9'b1_0_000_0_000) begin
            errors++;
            $display("FAIL reset_state obs=%b exp=%b", obs, 9'b1_0_000_0_000);
        end
        #3 aresetn = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (obs !== 9'b1_0_000_0_000) begin
            errors++;
            $display("FAIL reset_release obs=%b exp=%b", obs, 9'b1_0_000_0_000);
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] b = 8'h55;
        logic       eb;
        int         k;
        rx_q.delete();
        step(1'b1, b, 1'b0, 1'b0);
        checks++;
        if (uart_tx !== 1'b1) begin
            errors++;
            $display("FAIL latency_edge1 uart_tx=%b exp=1", uart_tx);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (uart_tx !== 1'b0) begin
            errors++;
            $display("FAIL latency_edge2 uart_tx=%b exp=0", uart_tx);
        end
        for (int i = 1; i <= FRAME; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL single_cycle i=%0d obs=%b exp=%b", i, obs, exp_vec());
            end
            k = i / CPB;
            if ((i % CPB) == CPB / 2 && k < 10) begin
                eb = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
                checks++;
                if (uart_tx !== eb) begin
                    errors++;
                    $display("FAIL single_bit k=%0d uart_tx=%b exp=%b", k, uart_tx, eb);
                end
            end
            if (i == FRAME - 1) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL single_busy_last busy=%b exp=1", busy);
                end
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy_end busy=%b exp=0", busy);
        end
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== b) begin
            errors++;
            $display("FAIL single_rx count=%0d exp=1 byte=%h exp=%h", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00, b);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes[3] = '{8'h41, 8'h42, 8'h43};
        int         peak = 0;
        int         n = 0;
        rx_q.delete();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, bytes[i], 1'b0, 1'b0);
            if (int'(level) > peak) peak = int'(level);
            if (i == 1) begin
                checks++;
                if (uart_tx !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_start uart_tx=%b exp=0", uart_tx);
                end
            end
            if (i >= 1) n++;
        end
        n = 1;
        while (busy === 1'b1 && n < 400) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            if (int'(level) > peak) peak = int'(level);
            n++;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_cycle n=%0d obs=%b exp=%b", n, obs, exp_vec());
            end
        end
        checks++;
        if (peak != 2) begin
            errors++;
            $display("FAIL b2b_peak level=%0d exp=2", peak);
        end
        checks++;
        if (n != 3 * FRAME) begin
            errors++;
            $display("FAIL b2b_duration cycles=%0d exp=%0d", n, 3 * FRAME);
        end
        checks++;
        if (rx_q.size() != 3 || rx_q[0] !== 8'h41 || rx_q[1] !== 8'h42 || rx_q[2] !== 8'h43) begin
            errors++;
            $display("FAIL b2b_rx count=%0d exp=3", rx_q.size());
        end
    endtask

    task automatic test_overflow();
        logic [7:0] b[6];
        int         n = 0;
        bit         ok;
        rx_q.delete();
        for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, b[i], 1'b0, 1'b0);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL ovf_push i=%0d obs=%b exp=%b", i, obs, exp_vec());
            end
        end
        checks++;
        if (overflow !== 1'b1 || drop_count !== CW'(1)) begin
            errors++;
            $display("FAIL ovf_status overflow=%b drop_count=%0d exp 1/1", overflow, drop_count);
        end
        while (busy === 1'b1 && n < 400) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            n++;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL ovf_cycle n=%0d obs=%b exp=%b", n, obs, exp_vec());
            end
        end
        ok = (rx_q.size() == 5);
        for (int i = 0; i < 5 && ok; i++) if (rx_q[i] !== b[i]) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ovf_rx count=%0d exp=5 (bytes differ from first five inputs)", rx_q.size());
        end
    endtask

    task automatic test_push_at_stop();
        logic [CW-1:0] dc_before;
        int            n = 0;
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        while (m_rem != 1 && n < 60) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            n++;
        end
        checks++;
        if (level !== 3'd4 || n >= 60) begin
            errors++;
            $display("FAIL stop_setup level=%0d exp=4 wait=%0d", level, n);
        end
        dc_before = drop_count;
        step(1'b1, 8'($urandom), 1'b0, 1'b0);
        checks++;
        if (level !== 3'd4 || drop_count !== dc_before) begin
            errors++;
            $display("FAIL stop_push level=%0d exp=4 drop_count=%0d exp=%0d", level, drop_count, dc_before);
        end
        step(1'b1, 8'($urandom), 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b0 || drop_count !== '0) begin
            errors++;
            $display("FAIL clear_vs_drop overflow=%b drop_count=%0d exp 0/0", overflow, drop_count);
        end
        for (int i = 0; i < MAXD + 2; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        checks++;
        if (overflow !== 1'b1 || drop_count !== CW'(MAXD)) begin
            errors++;
            $display("FAIL drop_saturate overflow=%b drop_count=%0d exp 1/%0d", overflow, drop_count, MAXD);
        end
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            n++;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL stop_drain n=%0d obs=%b exp=%b", n, obs, exp_vec());
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_drain_timeout busy=%b exp=0", busy);
        end
    endtask

    task automatic test_flush();
        int n = 0;
        rx_q.delete();
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        step(1'b1, 8'h17, 1'b0, 1'b0);
        step(1'b1, 8'h29, 1'b0, 1'b0);
        while (m_rem != FRAME - 5 * CPB - 1 && n < 60) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            n++;
        end
        checks++;
        if (level !== 3'd2 || n >= 60) begin
            errors++;
            $display("FAIL flush_setup level=%0d exp=2 wait=%0d", level, n);
        end
        step(1'b1, 8'hEE, 1'b1, 1'b0);
        checks++;
        if (obs !== 9'b1_0_000_0_000) begin
            errors++;
            $display("FAIL flush_state obs=%b exp=%b", obs, 9'b1_0_000_0_000);
        end
        for (int i = 0; i < 3 * FRAME; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            checks++;
            if (obs !== 9'b1_0_000_0_000) begin
                errors++;
                $display("FAIL flush_quiet i=%0d obs=%b exp=%b", i, obs, 9'b1_0_000_0_000);
            end
        end
        checks++;
        if (rx_q.size() != 0) begin
            errors++;
            $display("FAIL flush_rx count=%0d exp=0", rx_q.size());
        end
    endtask

    task automatic test_async_reset();
        int n = 0;
        step(1'b1, 8'h33, 1'b0, 1'b0);
        step(1'b1, 8'h44, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
        #3 aresetn = 1'b0;
        #1;
        checks++;
        if (obs !== 9'b1_0_000_0_000) begin
            errors++;
            $display("FAIL async_reset obs=%b exp=%b", obs, 9'b1_0_000_0_000);
        end
        model_reset();
        step(1'b1, 8'h99, 1'b0, 1'b0);
        step(1'b1, 8'h98, 1'b0, 1'b0);
        #2 aresetn = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (obs !== 9'b1_0_000_0_000) begin
            errors++;
            $display("FAIL async_release obs=%b exp=%b", obs, 9'b1_0_000_0_000);
        end
        rx_q.delete();
        step(1'b1, 8'h0D, 1'b0, 1'b0);
        while ((busy === 1'b1 || n == 0) && n < 200) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            n++;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL async_cycle n=%0d obs=%b exp=%b", n, obs, exp_vec());
            end
        end
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h0D) begin
            errors++;
            $display("FAIL async_rx count=%0d exp=1 byte=%h exp=0d", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00);
        end
    endtask

    task automatic test_random();
        logic v;
        logic fl;
        logic cs;
        for (int i = 0; i < 3000; i++) begin
            v  = ($urandom_range(0, 99) < 35);
            fl = ($urandom_range(0, 999) < 4);
            cs = ($urandom_range(0, 99) < 2);
            step(v, 8'($urandom), fl, cs);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random_cycle i=%0d obs=%b exp=%b", i, obs, exp_vec());
            end
        end
        checks++;
        if (rx_ferr != 0) begin
            errors++;
            $display("FAIL framing_errors count=%0d exp=0", rx_ferr);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_push_at_stop();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
